// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the two-input gate checker.
// Gate bit order matches the gate unit's output bus.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int unsigned GATE_AND  = 0;
  localparam int unsigned GATE_OR   = 1;
  localparam int unsigned GATE_NAND = 2;
  localparam int unsigned GATE_NOR  = 3;
  localparam int unsigned GATE_XOR  = 4;
  localparam int unsigned GATE_XNOR = 5;
  localparam int unsigned GATE_NOT  = 6;
  localparam int unsigned NUM_GATES = 7;

  // Indexed by {a,b}: AB = 00, 01, 10, 11.
  localparam logic [NUM_GATES-1:0] EXP_VEC [4] = '{7'h6C, 7'h56, 7'h16, 7'h23};

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the gate unit: (a,b) -> expected 7-bit output.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] exp_vec
);

  always_comb begin
    exp_vec = EXP_VEC[{a, b}];
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps all four (A,B) vectors into a gate unit, checks its outputs
// against the reference model and reports pass/fail, mask and error count.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_GATES-1:0] gate_in,
  output logic                 a_out,
  output logic                 b_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2:0]           err_count,
  output logic [NUM_GATES-1:0] fail_mask
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("gate_truth_checker: SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t               state_q, state_d;
  logic [1:0]           vec_q, vec_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [2:0]           err_q, err_d;
  logic [NUM_GATES-1:0] mask_q, mask_d;

  logic [NUM_GATES-1:0] exp_vec;
  logic [NUM_GATES-1:0] diff;

  gate_ref_model u_ref (
    .a       (a_out),
    .b       (b_out),
    .exp_vec (exp_vec)
  );

  assign diff = gate_in ^ exp_vec;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    mask_d  = mask_q;

    // Abort outside IDLE takes priority over every other transition.
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      vec_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
      err_d   = '0;
      mask_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SETTLE;
            vec_d   = '0;
            cnt_d   = SETTLE_LOAD;
            busy_d  = 1'b1;
            pass_d  = 1'b0;
            err_d   = '0;
            mask_d  = '0;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        SAMPLE: begin
          mask_d = mask_q | diff;
          err_d  = err_q + {2'b00, |diff};
          if (vec_q == 2'd3) begin
            state_d = DONE;
          end else begin
            vec_d   = vec_q + 2'd1;
            cnt_d   = SETTLE_LOAD;
            state_d = SETTLE;
          end
        end
        DONE: begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_q == '0);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  assign a_out     = vec_q[1];
  assign b_out     = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: two instances (SETTLE_CYCLES 2 and 1)
// each driven by a behavioural gate unit with selectable faults.
module tb_gate_truth_checker;
  import gate_chk_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  int   mode0 = 0, mode1 = 0;

  logic [6:0] gin0, gin1, mask0, mask1;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] err0, err1;

  int n_cmp = 0;
  int n_bad = 0;

  // mode 0: healthy, 1: XOR stuck at 0, 2: AND and NAND swapped
  function automatic logic [6:0] gate_fn(input logic a, input logic b, input int mode);
    logic [6:0] g;
    logic       t;
    g[GATE_AND]  = a & b;
    g[GATE_OR]   = a | b;
    g[GATE_NAND] = ~(a & b);
    g[GATE_NOR]  = ~(a | b);
    g[GATE_XOR]  = a ^ b;
    g[GATE_XNOR] = ~(a ^ b);
    g[GATE_NOT]  = ~a;
    if (mode == 1) g[GATE_XOR] = 1'b0;
    if (mode == 2) begin
      t            = g[GATE_AND];
      g[GATE_AND]  = g[GATE_NAND];
      g[GATE_NAND] = t;
    end
    return g;
  endfunction

  assign gin0 = gate_fn(a0, b0, mode0);
  assign gin1 = gate_fn(a1, b1, mode1);

  gate_truth_checker #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .gate_in(gin0),
    .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_mask(mask0)
  );

  gate_truth_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .gate_in(gin1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(mask1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep0(output int lat);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (done0) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [14:0] o0, o1;
    tick();
    tick();
    o0 = {a0, b0, busy0, done0, pass0, err0, mask0};
    o1 = {a1, b1, busy1, done1, pass1, err1, mask1};
    n_cmp++;
    if (o0 !== '0) begin n_bad++; $display("FAIL reset_dut0: got %h want 0", o0); end
    n_cmp++;
    if (o1 !== '0) begin n_bad++; $display("FAIL reset_dut1: got %h want 0", o1); end
    rst = 1'b0;
    tick();
    o0 = {a0, b0, busy0, done0, pass0, err0, mask0};
    n_cmp++;
    if (o0 !== '0) begin n_bad++; $display("FAIL post_reset_idle: got %h want 0", o0); end
  endtask

  task automatic test_correct();
    int         lat;
    logic [1:0] e_ab;
    mode0 = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      if (done0) begin
        lat = k;
        break;
      end
      if (k <= 12) begin
        e_ab = (k / 3 > 3) ? 2'd3 : 2'(k / 3);
        n_cmp++;
        if ({a0, b0} !== e_ab) begin
          n_bad++; $display("FAIL ab_seq k=%0d: got %b want %b", k, {a0, b0}, e_ab);
        end
        n_cmp++;
        if (busy0 !== 1'b1) begin n_bad++; $display("FAIL busy_in_sweep k=%0d: got %b want 1", k, busy0); end
      end
      tick();
    end
    n_cmp++;
    if (lat !== 13) begin n_bad++; $display("FAIL latency_s2: got %0d want 13", lat); end
    n_cmp++;
    if ({pass0, err0, mask0} !== {1'b1, 3'd0, 7'h00}) begin
      n_bad++; $display("FAIL correct_result: got pass=%b err=%0d mask=%h want 1/0/00", pass0, err0, mask0);
    end
    n_cmp++;
    if (busy0 !== 1'b0) begin n_bad++; $display("FAIL busy_after_done: got %b want 0", busy0); end
    tick();
    n_cmp++;
    if ({done0, a0, b0, pass0} !== 4'b0111) begin
      n_bad++; $display("FAIL done_one_cycle: got done=%b ab=%b%b pass=%b want 0 11 1", done0, a0, b0, pass0);
    end
  endtask

  task automatic test_stuck_xor();
    int lat;
    mode0 = 1;
    sweep0(lat);
    n_cmp++;
    if (lat !== 13) begin n_bad++; $display("FAIL stuck_xor_latency: got %0d want 13", lat); end
    n_cmp++;
    if ({pass0, err0, mask0} !== {1'b0, 3'd2, 7'h10}) begin
      n_bad++; $display("FAIL stuck_xor: got pass=%b err=%0d mask=%h want 0/2/10", pass0, err0, mask0);
    end
  endtask

  task automatic test_swap();
    int lat;
    mode0 = 2;
    sweep0(lat);
    n_cmp++;
    if ({pass0, err0, mask0} !== {1'b0, 3'd4, 7'h05}) begin
      n_bad++; $display("FAIL and_nand_swap: got pass=%b err=%0d mask=%h want 0/4/05", pass0, err0, mask0);
    end
  endtask

  task automatic test_abort();
    int          lat;
    int          seen;
    logic [14:0] o0;
    mode0 = 1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    n_cmp++;
    if ({busy0, a0, b0, err0, mask0} !== {1'b1, 2'b10, 3'd1, 7'h10}) begin
      n_bad++; $display("FAIL pre_abort: got busy=%b ab=%b%b err=%0d mask=%h want 1 10 1 10",
                        busy0, a0, b0, err0, mask0);
    end
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    o0 = {a0, b0, busy0, done0, pass0, err0, mask0};
    n_cmp++;
    if (o0 !== '0) begin n_bad++; $display("FAIL abort_clear: got %h want 0", o0); end
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done0 || busy0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d busy/done cycles want 0", seen); end
    mode0 = 0;
    sweep0(lat);
    n_cmp++;
    if ({lat, pass0, err0} !== {32'd13, 1'b1, 3'd0}) begin
      n_bad++; $display("FAIL after_abort_sweep: got lat=%0d pass=%b err=%0d want 13/1/0", lat, pass0, err0);
    end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [14:0] o0;
    mode0 = 1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    n_cmp++;
    if ({busy0, a0, b0} !== 3'b101) begin
      n_bad++; $display("FAIL pre_reset_vec1: got busy=%b ab=%b%b want 1 01", busy0, a0, b0);
    end
    rst = 1'b1;
    #2;
    o0 = {a0, b0, busy0, done0, pass0, err0, mask0};
    n_cmp++;
    if (o0 !== '0) begin n_bad++; $display("FAIL async_reset: got %h want 0", o0); end
    tick();
    rst = 1'b0;
    tick();
    o0 = {a0, b0, busy0, done0, pass0, err0, mask0};
    n_cmp++;
    if (o0 !== '0) begin n_bad++; $display("FAIL reset_release: got %h want 0", o0); end
    mode0 = 0;
    sweep0(lat);
    n_cmp++;
    if ({lat, pass0, err0, mask0} !== {32'd13, 1'b1, 3'd0, 7'h00}) begin
      n_bad++; $display("FAIL after_reset_sweep: got lat=%0d pass=%b err=%0d mask=%h want 13/1/0/00",
                        lat, pass0, err0, mask0);
    end
  endtask

  task automatic test_start_busy();
    int lat;
    mode1 = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      start1 = (n == 3 || n == 7);
      tick();
      start1 = 1'b0;
      if (done1) begin
        lat = n;
        break;
      end
    end
    n_cmp++;
    if (lat !== 9) begin n_bad++; $display("FAIL latency_s1_restart: got %0d want 9", lat); end
    n_cmp++;
    if ({pass1, err1, mask1} !== {1'b1, 3'd0, 7'h00}) begin
      n_bad++; $display("FAIL s1_result: got pass=%b err=%0d mask=%h want 1/0/00", pass1, err1, mask1);
    end
  endtask

  task automatic test_start_abort_idle();
    int lat;
    tick();
    start1 = 1'b1;
    abort1 = 1'b1;
    tick();
    start1 = 1'b0;
    abort1 = 1'b0;
    n_cmp++;
    if (busy1 !== 1'b1) begin n_bad++; $display("FAIL start_beats_abort: got busy=%b want 1", busy1); end
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (done1) begin
        lat = n;
        break;
      end
    end
    n_cmp++;
    if (lat !== 9) begin n_bad++; $display("FAIL start_abort_latency: got %0d want 9", lat); end
  endtask

  task automatic test_abort_in_done();
    mode1 = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 1; n <= 8; n++) tick();
    n_cmp++;
    if ({busy1, done1, a1, b1} !== 4'b1011) begin
      n_bad++; $display("FAIL in_done_state: got busy=%b done=%b ab=%b%b want 1 0 11", busy1, done1, a1, b1);
    end
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    n_cmp++;
    if ({done1, busy1, pass1, a1, b1, err1, mask1} !== '0) begin
      n_bad++; $display("FAIL abort_wins_done: got done=%b busy=%b pass=%b ab=%b%b want all 0",
                        done1, busy1, pass1, a1, b1);
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_stuck_xor();
    test_swap();
    test_abort();
    test_reset_mid();
    test_start_busy();
    test_start_abort_idle();
    test_abort_in_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, sweep never ended");
    $fatal(1, "watchdog expired");
  end

endmodule
